// File: rtl/register_file_sb_pkg.sv
// rtl/register_file_sb_pkg.sv - shared widths and types for the integer register file
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;
endpackage

// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - decode/writeback bus of the register file
interface register_file_sb_if
  import rv_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int NUM_REGS = NREGS,
  parameter int NUM_READ = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_READ-1:0][AW-1:0]     read_address;
  logic [NUM_READ-1:0][DATA_W-1:0] read_data;
  logic [NUM_READ-1:0]             read_pending;
  logic                            write_enable;
  logic [AW-1:0]                   write_address;
  logic [DATA_W-1:0]               write_data;
  logic                            reserve_enable;
  logic [AW-1:0]                   reserve_address;
  logic                            reserve_ok;
  logic [AW:0]                     pending_count;

  modport master (
    output read_address, write_enable, write_address, write_data,
           reserve_enable, reserve_address,
    input  read_data, read_pending, reserve_ok, pending_count
  );

  modport slave (
    input  read_address, write_enable, write_address, write_data,
           reserve_enable, reserve_address,
    output read_data, read_pending, reserve_ok, pending_count
  );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// rtl/register_file_sb_scoreboard.sv - per-register pending bits, reservation check and pending counter
module register_scoreboard
  import rv_pkg::*;
#(
  parameter int NUM_REGS = NREGS,
  parameter int NUM_Q    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reserve_enable,
  input  logic [AW-1:0]          reserve_address,
  input  logic                   clear_enable,
  input  logic [AW-1:0]          clear_address,
  input  logic [NUM_Q-1:0][AW-1:0] query_address,
  output logic [NUM_Q-1:0]       query_pending,
  output logic                   reserve_ok,
  output logic [AW:0]            pending_count
);
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                clear_ok;
  logic                reserve_zero;
  logic                count_dec;

  assign clear_ok     = clear_enable && !(ZERO_REG != 0 && clear_address == '0);
  assign reserve_zero = (ZERO_REG != 0) && (reserve_address == '0);
  // A writeback retiring the same register frees it in time for a new owner.
  assign reserve_ok   = reserve_enable && !reserve_zero &&
                        (!pending[reserve_address] ||
                         (clear_ok && clear_address == reserve_address));
  assign count_dec    = clear_ok && pending[clear_address];

  always_comb begin
    pending_nxt = pending;
    if (clear_ok) pending_nxt[clear_address] = 1'b0;
    if (reserve_ok) pending_nxt[reserve_address] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      query_pending[i] = pending[query_address[i]] &&
                         !(ZERO_REG != 0 && query_address[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pending_nxt;
      pending_count <= pending_count + {{AW{1'b0}}, reserve_ok}
                                     - {{AW{1'b0}}, count_dec};
    end
  end
endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with write bypass and hazard scoreboard
module register_file_sb #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int NREGS    = rv_pkg::NREGS,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic              clk,
  input logic              reset,
  register_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREAD-1:0] query_pending;
  logic             write_ok;

  assign write_ok = bus.write_enable && !(ZERO_REG != 0 && bus.write_address == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (write_ok) begin
      regs[bus.write_address] <= bus.write_data;
    end
  end

  // x0 override is applied last so it wins over the bypass.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      bus.read_data[i]    = regs[bus.read_address[i]];
      bus.read_pending[i] = query_pending[i];
      if (BYPASS != 0 && write_ok && bus.write_address == bus.read_address[i]) begin
        bus.read_data[i]    = bus.write_data;
        bus.read_pending[i] = 1'b0;
      end
      if (ZERO_REG != 0 && bus.read_address[i] == '0) begin
        bus.read_data[i]    = '0;
        bus.read_pending[i] = 1'b0;
      end
    end
  end

  register_scoreboard #(
    .NUM_REGS (NREGS),
    .NUM_Q    (NREAD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .reserve_enable  (bus.reserve_enable),
    .reserve_address (bus.reserve_address),
    .clear_enable    (bus.write_enable),
    .clear_address   (bus.write_address),
    .query_address   (bus.read_address),
    .query_pending   (query_pending),
    .reserve_ok      (bus.reserve_ok),
    .pending_count   (bus.pending_count)
  );
endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - scoreboard bench for a bypassing 2-port build and a 4-port 16-register non-bypass build
module tb_register_file_sb;
  import rv_pkg::*;

  localparam int K_RD  = 0;
  localparam int K_RP  = 1;
  localparam int K_OK  = 2;
  localparam int K_CNT = 3;

  typedef struct {
    int          dut;
    int          kind;
    int          idx;
    logic [31:0] value;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  reg_data_t mb [16];

  always #5 clk = ~clk;

  register_file_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_READ(2)) ia ();
  register_file_sb_if #(.DATA_W(32), .NUM_REGS(16), .NUM_READ(4)) ib ();

  register_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  register_file_sb #(.XLEN(32), .NREGS(16), .NREAD(4), .BYPASS(0), .ZERO_REG(1))
    dut_b (.clk(clk), .reset(reset), .bus(ib));

  function automatic logic [31:0] actual(exp_t e);
    logic [31:0] v;
    v = 32'hxxxx_xxxx;
    if (e.dut == 0) begin
      case (e.kind)
        K_RD:  v = ia.read_data[e.idx];
        K_RP:  v = {31'd0, ia.read_pending[e.idx]};
        K_OK:  v = {31'd0, ia.reserve_ok};
        K_CNT: v = {26'd0, ia.pending_count};
        default: v = 32'hxxxx_xxxx;
      endcase
    end else begin
      case (e.kind)
        K_RD:  v = ib.read_data[e.idx];
        K_RP:  v = {31'd0, ib.read_pending[e.idx]};
        K_OK:  v = {31'd0, ib.reserve_ok};
        K_CNT: v = {27'd0, ib.pending_count};
        default: v = 32'hxxxx_xxxx;
      endcase
    end
    return v;
  endfunction

  // Monitor: drains every expectation queued for this cycle at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual(e);
      checks++;
      if (a !== e.value) begin
        errors++;
        $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                 e.name, a, a, e.value, e.value);
      end
    end
  end

  task automatic expect_val(int dut, int kind, int idx, logic [31:0] value, string name);
    exp_t e;
    e.dut = dut; e.kind = kind; e.idx = idx; e.value = value; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.write_enable = 1'b0;
    ia.reserve_enable = 1'b0;
  endtask

  task automatic write_a(int addr, logic [31:0] data);
    ia.write_enable = 1'b1;
    ia.write_address = 5'(addr);
    ia.write_data = data;
  endtask

  task automatic reserve_a(int addr);
    ia.reserve_enable = 1'b1;
    ia.reserve_address = 5'(addr);
  endtask

  task automatic read_a(int a0, int a1);
    ia.read_address[0] = 5'(a0);
    ia.read_address[1] = 5'(a1);
  endtask

  task automatic read_b(int a0, int a1, int a2, int a3);
    ib.read_address[0] = 4'(a0);
    ib.read_address[1] = 4'(a1);
    ib.read_address[2] = 4'(a2);
    ib.read_address[3] = 4'(a3);
  endtask

  initial begin
    int waddr [6];
    waddr = '{9, 10, 15, 1, 7, 9};
    for (int r = 0; r < 16; r++) mb[r] = '0;

    reset = 1'b1;
    idle_a(); read_a(0, 0); ia.write_address = '0; ia.write_data = '0; ia.reserve_address = '0;
    ib.write_enable = 1'b0; ib.reserve_enable = 1'b0; read_b(0, 0, 0, 0);
    ib.write_address = '0; ib.write_data = '0; ib.reserve_address = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    read_a(0, 5);
    expect_val(0, K_RD, 0, 0, "rst_rd_x0"); expect_val(0, K_RD, 1, 0, "rst_rd_x5");
    expect_val(0, K_RP, 0, 0, "rst_rp_x0"); expect_val(0, K_RP, 1, 0, "rst_rp_x5");
    expect_val(0, K_CNT, 0, 0, "rst_cnt_a"); expect_val(1, K_CNT, 0, 0, "rst_cnt_b");

    // x0 is hardwired
    tick(); write_a(0, 99); read_a(0, 0);
    expect_val(0, K_RD, 0, 0, "x0_bypass");
    tick(); idle_a();
    expect_val(0, K_RD, 0, 0, "x0_after_write");

    // Plain writes then two-port read
    tick(); write_a(1, 1234);
    tick(); write_a(2, 5678);
    tick(); idle_a(); read_a(2, 1);
    expect_val(0, K_RD, 0, 5678, "rd_x2"); expect_val(0, K_RD, 1, 1234, "rd_x1");

    // Same-cycle bypass
    tick(); write_a(3, 42); read_a(3, 3);
    expect_val(0, K_RD, 0, 42, "bypass_x3"); expect_val(0, K_RP, 0, 0, "bypass_rp_x3");
    tick(); idle_a();
    expect_val(0, K_RD, 1, 42, "after_bypass_x3");

    // Reserve, WAW stall, writeback clears
    tick(); reserve_a(4);
    expect_val(0, K_OK, 0, 1, "reserve_x4_ok");
    tick(); idle_a(); read_a(4, 0);
    expect_val(0, K_RP, 0, 1, "x4_pending"); expect_val(0, K_CNT, 0, 1, "cnt_after_x4");
    tick(); reserve_a(4);
    expect_val(0, K_OK, 0, 0, "rereserve_x4_refused");
    tick(); idle_a();
    expect_val(0, K_CNT, 0, 1, "cnt_after_refused"); expect_val(0, K_RP, 0, 1, "x4_still_pending");
    tick(); write_a(4, 7);
    expect_val(0, K_RD, 0, 7, "bypass_x4"); expect_val(0, K_RP, 0, 0, "bypass_rp_x4");
    tick(); idle_a();
    expect_val(0, K_RD, 0, 7, "rd_x4"); expect_val(0, K_RP, 0, 0, "x4_cleared");
    expect_val(0, K_CNT, 0, 0, "cnt_after_clear");

    // Write and reserve the same pending register
    tick(); reserve_a(5);
    tick(); idle_a(); write_a(5, 11); reserve_a(5);
    expect_val(0, K_OK, 0, 1, "same_addr_reserve_ok");
    tick(); idle_a(); read_a(5, 0);
    expect_val(0, K_RD, 0, 11, "same_addr_data"); expect_val(0, K_RP, 0, 1, "same_addr_pending");
    expect_val(0, K_CNT, 0, 1, "same_addr_cnt");

    // Different-address write/reserve, then two more reservations
    tick(); write_a(5, 12); reserve_a(6);
    expect_val(0, K_OK, 0, 1, "reserve_x6_ok");
    tick(); idle_a(); reserve_a(7);
    expect_val(0, K_CNT, 0, 1, "cnt_after_x6");
    tick(); reserve_a(8);
    tick(); idle_a(); read_a(6, 5);
    expect_val(0, K_CNT, 0, 3, "cnt_three"); expect_val(0, K_RP, 0, 1, "x6_pending");
    expect_val(0, K_RP, 1, 0, "x5_cleared"); expect_val(0, K_RD, 1, 12, "rd_x5");

    // Reset with a concurrent write
    tick(); reset = 1'b1; write_a(6, 9);
    tick(); reset = 1'b0; idle_a(); read_a(6, 8);
    expect_val(0, K_RD, 0, 0, "rst_drop_x6"); expect_val(0, K_RP, 0, 0, "rst_rp_x6");
    expect_val(0, K_RP, 1, 0, "rst_rp_x8"); expect_val(0, K_CNT, 0, 0, "rst_cnt_again");
    tick(); read_a(1, 2); reserve_a(0);
    expect_val(0, K_RD, 0, 0, "rst_x1"); expect_val(0, K_RD, 1, 0, "rst_x2");
    expect_val(0, K_OK, 0, 0, "reserve_x0_a");
    tick(); idle_a();

    // Non-bypass 4-port build
    ib.write_enable = 1'b1; ib.write_address = 4'd3; ib.write_data = 32'd42; read_b(3, 0, 0, 0);
    expect_val(1, K_RD, 0, 0, "nobypass_old_x3");
    tick(); ib.write_enable = 1'b0; mb[3] = 32'd42;
    expect_val(1, K_RD, 0, 42, "nobypass_new_x3");
    for (int k = 0; k < 6; k++) begin
      tick();
      ib.write_enable = 1'b1; ib.write_address = 4'(waddr[k]); ib.write_data = $urandom;
      mb[waddr[k]] = ib.write_data;
    end
    tick(); ib.write_enable = 1'b0; read_b(9, 10, 15, 1);
    for (int p = 0; p < 4; p++) expect_val(1, K_RD, p, mb[ib.read_address[p]], $sformatf("b_port%0d", p));
    tick(); read_b(7, 3, 0, 9);
    expect_val(1, K_RD, 0, mb[7], "b_x7"); expect_val(1, K_RD, 1, 42, "b_x3");
    expect_val(1, K_RD, 2, 0, "b_x0"); expect_val(1, K_RD, 3, mb[9], "b_x9");
    tick(); read_b(10, 10, 10, 10);
    for (int p = 0; p < 4; p++) expect_val(1, K_RD, p, mb[10], $sformatf("b_same%0d", p));
    ib.reserve_enable = 1'b1; ib.reserve_address = 4'd0;
    expect_val(1, K_OK, 0, 0, "reserve_x0_b");
    tick(); ib.reserve_address = 4'd15;
    expect_val(1, K_OK, 0, 1, "reserve_x15_b");
    tick(); ib.reserve_enable = 1'b0; read_b(15, 0, 0, 0);
    ib.write_enable = 1'b1; ib.write_address = 4'd15; ib.write_data = 32'd1;
    expect_val(1, K_RP, 0, 1, "b_x15_pending_no_bypass");
    expect_val(1, K_RD, 0, mb[15], "b_x15_old");
    expect_val(1, K_CNT, 0, 1, "b_cnt_one");
    tick(); ib.write_enable = 1'b0;
    expect_val(1, K_RP, 0, 0, "b_x15_cleared"); expect_val(1, K_RD, 0, 1, "b_x15_new");
    expect_val(1, K_CNT, 0, 0, "b_cnt_zero");

    tick(); tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
